// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//   Program-counter sequencer for the WISC CPU front end. Holds the PC, the
//   clocked Z/N/V flags and a hardware return-address stack (RAS), evaluates
//   branch conditions, and runs a RUN/HALT state machine.
//
// Ports
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   stall           freeze all state this cycle
//   branch/cond/br_off      conditional branch, condition code, signed offset
//   call/call_off           call with signed offset (pushes pc+1)
//   ret/ret_reg             return; ret_reg used only when the RAS is empty
//   halt_in                 HLT instruction
//   set_z/set_nv            flag update strobes for alu_z / alu_n, alu_v
//   pc                      current PC (registered)
//   pc_plus1                pc+1, link value for the call write-back (comb)
//   hlt                     1 while halted
//   z_flag/n_flag/v_flag    registered flags
//   ras_empty/ras_full      RAS occupancy
//   ras_ovf                 sticky: a call was pushed while the RAS was full
// ---------------------------------------------------------------------------
module pc_sequencer #(
  parameter int unsigned   PC_W       = 16,
  parameter int unsigned   BR_IMM_W   = 9,
  parameter int unsigned   CALL_IMM_W = 12,
  parameter int unsigned   RAS_DEPTH  = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  branch,
  input  logic [2:0]            cond,
  input  logic [BR_IMM_W-1:0]   br_off,
  input  logic                  call,
  input  logic [CALL_IMM_W-1:0] call_off,
  input  logic                  ret,
  input  logic [PC_W-1:0]       ret_reg,
  input  logic                  halt_in,
  input  logic                  set_z,
  input  logic                  set_nv,
  input  logic                  alu_z,
  input  logic                  alu_n,
  input  logic                  alu_v,
  output logic [PC_W-1:0]       pc,
  output logic [PC_W-1:0]       pc_plus1,
  output logic                  hlt,
  output logic                  z_flag,
  output logic                  n_flag,
  output logic                  v_flag,
  output logic                  ras_empty,
  output logic                  ras_full,
  output logic                  ras_ovf
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t state, state_next;

  // Datapath next-values and RAS controls
  logic              en;
  logic [PC_W-1:0]   pc_next;
  logic              z_next, n_next, v_next;
  logic              push, pop;
  logic              taken;
  logic [PC_W-1:0]   br_sext, call_sext;

  // RAS storage: wr_ptr is the next free slot, rd_ptr the current top
  logic [PC_W-1:0]   ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  ras_cnt;
  logic [PC_W-1:0]   ras_top;

  assign pc_plus1  = pc + PC_W'(1);
  assign br_sext   = {{(PC_W-BR_IMM_W){br_off[BR_IMM_W-1]}}, br_off};
  assign call_sext = {{(PC_W-CALL_IMM_W){call_off[CALL_IMM_W-1]}}, call_off};
  assign rd_ptr    = wr_ptr - PTR_W'(1);
  assign ras_top   = ras_mem[rd_ptr];
  assign ras_empty = (ras_cnt == CNT_W'(0));
  assign ras_full  = (ras_cnt == CNT_W'(RAS_DEPTH));
  assign hlt       = (state == ST_HALT);

  // Branch condition from the flags as registered before this edge
  always_comb begin
    taken = 1'b0;
    case (cond)
      3'b000:  taken = ~z_flag;
      3'b001:  taken = z_flag;
      3'b010:  taken = ~z_flag & ~n_flag;
      3'b011:  taken = n_flag;
      3'b100:  taken = z_flag | ~n_flag;
      3'b101:  taken = z_flag | n_flag;
      3'b110:  taken = v_flag;
      default: taken = 1'b1;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_next;
  end

  // FSM next-state: HALT is terminal until reset
  always_comb begin
    state_next = state;
    if (state == ST_RUN && !stall && halt_in) state_next = ST_HALT;
  end

  // FSM outputs: next PC, flag updates and RAS push/pop by priority
  always_comb begin
    en      = ~stall & (state == ST_RUN);
    pc_next = pc;
    z_next  = z_flag;
    n_next  = n_flag;
    v_next  = v_flag;
    push    = 1'b0;
    pop     = 1'b0;
    if (en && !halt_in) begin
      if (set_z)  z_next = alu_z;
      if (set_nv) begin
        n_next = alu_n;
        v_next = alu_v;
      end
      if (call) begin
        pc_next = pc_plus1 + call_sext;
        push    = 1'b1;
      end else if (ret) begin
        pc_next = ras_empty ? ret_reg : ras_top;
        pop     = ~ras_empty;
      end else if (branch && taken) begin
        pc_next = pc_plus1 + br_sext;
      end else begin
        pc_next = pc_plus1;
      end
    end
  end

  // PC and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      z_flag <= 1'b0;
      n_flag <= 1'b0;
      v_flag <= 1'b0;
    end else begin
      pc     <= pc_next;
      z_flag <= z_next;
      n_flag <= n_next;
      v_flag <= v_next;
    end
  end

  // RAS pointer/count; a push while full overwrites the oldest entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      ras_cnt <= '0;
      ras_ovf <= 1'b0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PTR_W'(1);
      if (ras_full) ras_ovf <= 1'b1;
      else          ras_cnt <= ras_cnt + CNT_W'(1);
    end else if (pop) begin
      wr_ptr  <= rd_ptr;
      ras_cnt <= ras_cnt - CNT_W'(1);
    end
  end

  // RAS entry storage (no reset needed; occupancy is tracked by ras_cnt)
  always_ff @(posedge clk) begin
    if (push) ras_mem[wr_ptr] <= pc_plus1;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//   Directed scoreboard bench for pc_sequencer. The stimulus process drives
//   inputs on the falling edge and queues the state expected after the next
//   rising edge; a monitor process pops and compares after each rising edge.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branch, call, ret, halt_in;
  logic [2:0]  cond;
  logic [8:0]  br_off;
  logic [11:0] call_off;
  logic [15:0] ret_reg;
  logic        set_z, set_nv, alu_z, alu_n, alu_v;
  logic [15:0] pc, pc_plus1;
  logic        hlt, z_flag, n_flag, v_flag, ras_empty, ras_full, ras_ovf;

  typedef struct packed {
    logic        stall, branch, call, ret, halt_in;
    logic [2:0]  cond;
    logic [8:0]  br_off;
    logic [11:0] call_off;
    logic [15:0] ret_reg;
    logic        set_z, set_nv, alu_z, alu_n, alu_v;
  } stim_t;

  typedef struct packed {
    logic [15:0] pc;
    logic        hlt, z, n, v, empty, full, ovf;
  } exp_t;

  stim_t s;
  exp_t  e;
  exp_t  mx;
  exp_t  q[$];
  int    n_chk  = 0;
  int    n_pass = 0;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch(branch), .cond(cond),
    .br_off(br_off), .call(call), .call_off(call_off), .ret(ret),
    .ret_reg(ret_reg), .halt_in(halt_in), .set_z(set_z), .set_nv(set_nv),
    .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v), .pc(pc), .pc_plus1(pc_plus1),
    .hlt(hlt), .z_flag(z_flag), .n_flag(n_flag), .v_flag(v_flag),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_ovf(ras_ovf)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, want, $time);
  endfunction

  task automatic check_state(exp_t x, string tag);
    chk({tag, " pc"},        32'(pc),        32'(x.pc));
    chk({tag, " pc_plus1"},  32'(pc_plus1),  32'(x.pc + 16'd1));
    chk({tag, " hlt"},       32'(hlt),       32'(x.hlt));
    chk({tag, " z_flag"},    32'(z_flag),    32'(x.z));
    chk({tag, " n_flag"},    32'(n_flag),    32'(x.n));
    chk({tag, " v_flag"},    32'(v_flag),    32'(x.v));
    chk({tag, " ras_empty"}, 32'(ras_empty), 32'(x.empty));
    chk({tag, " ras_full"},  32'(ras_full),  32'(x.full));
    chk({tag, " ras_ovf"},   32'(ras_ovf),   32'(x.ovf));
  endtask

  // Monitor: compare the queued expectation after each rising edge
  always begin
    @(posedge clk);
    #1;
    if (q.size() != 0) begin
      mx = q.pop_front();
      check_state(mx, "step");
    end
  end

  task automatic clr();
    s = '0;
  endtask

  task automatic step();
    @(negedge clk);
    rst_n    = 1'b1;
    stall    = s.stall;    branch  = s.branch;  cond    = s.cond;
    br_off   = s.br_off;   call    = s.call;    call_off = s.call_off;
    ret      = s.ret;      ret_reg = s.ret_reg; halt_in = s.halt_in;
    set_z    = s.set_z;    set_nv  = s.set_nv;
    alu_z    = s.alu_z;    alu_n   = s.alu_n;   alu_v   = s.alu_v;
    q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    clr();
    {stall, branch, call, ret, halt_in, set_z, set_nv, alu_z, alu_n, alu_v} = '0;
    cond = '0; br_off = '0; call_off = '0; ret_reg = '0;
    e = '{pc: 16'h0000, hlt: 1'b0, z: 1'b0, n: 1'b0, v: 1'b0,
          empty: 1'b1, full: 1'b0, ovf: 1'b0};
    #1;
    check_state(e, "reset");

    // Sequential run after reset: 1,2,3
    for (int i = 1; i <= 3; i++) begin
      clr(); e.pc = 16'(i); step();
    end

    // Z set then EQ branch back by -2
    clr(); s.ret = 1'b1; s.ret_reg = 16'h0010; e.pc = 16'h0010; step();
    clr(); s.set_z = 1'b1; s.alu_z = 1'b1; e.pc = 16'h0011; e.z = 1'b1; step();
    clr(); s.branch = 1'b1; s.cond = 3'b001; s.br_off = 9'h1FE; e.pc = 16'h0010; step();
    // Same, with NE (not taken)
    clr(); s.set_z = 1'b1; s.alu_z = 1'b1; e.pc = 16'h0011; step();
    clr(); s.branch = 1'b1; s.cond = 3'b000; s.br_off = 9'h1FE; e.pc = 16'h0012; step();
    // Flag write and branch together: branch uses old Z=1
    clr(); s.set_z = 1'b1; s.alu_z = 1'b0; s.branch = 1'b1; s.cond = 3'b001;
    s.br_off = 9'h1FE; e.pc = 16'h0011; e.z = 1'b0; step();
    clr(); s.branch = 1'b1; s.cond = 3'b001; s.br_off = 9'h1FE; e.pc = 16'h0012; step();
    // N,V set; OV taken, GT not taken, LT taken
    clr(); s.set_nv = 1'b1; s.alu_n = 1'b1; s.alu_v = 1'b1;
    e.pc = 16'h0013; e.n = 1'b1; e.v = 1'b1; step();
    clr(); s.branch = 1'b1; s.cond = 3'b110; s.br_off = 9'h005; e.pc = 16'h0019; step();
    clr(); s.branch = 1'b1; s.cond = 3'b010; s.br_off = 9'h005; e.pc = 16'h001A; step();
    clr(); s.branch = 1'b1; s.cond = 3'b011; s.br_off = 9'h003; e.pc = 16'h001E; step();

    // Call / ret
    clr(); s.ret = 1'b1; s.ret_reg = 16'h0020; e.pc = 16'h0020; step();
    clr(); s.call = 1'b1; s.call_off = 12'h010; e.pc = 16'h0031; e.empty = 1'b0; step();
    clr(); e.pc = 16'h0032; step();
    clr(); s.ret = 1'b1; s.ret_reg = 16'hBEEF; e.pc = 16'h0021; e.empty = 1'b1; step();

    // Stall with call and set_nv: nothing changes; then applies
    clr(); s.stall = 1'b1; s.call = 1'b1; s.call_off = 12'h010; s.set_nv = 1'b1; step();
    clr(); s.call = 1'b1; s.call_off = 12'h010; s.set_nv = 1'b1;
    e.pc = 16'h0032; e.n = 1'b0; e.v = 1'b0; e.empty = 1'b0; step();
    clr(); s.ret = 1'b1; s.ret_reg = 16'hBEEF; e.pc = 16'h0022; e.empty = 1'b1; step();

    // Nine nested calls (offset 0) from 0x22: pushes 0x23..0x2B
    for (int k = 1; k <= 9; k++) begin
      clr(); s.call = 1'b1; s.call_off = 12'h000;
      e.pc = 16'(16'h0022 + k); e.empty = 1'b0;
      e.full = (k >= 8); e.ovf = (k >= 9);
      step();
    end
    // Eight rets return 0x2B..0x24 (oldest entry was overwritten)
    for (int k = 1; k <= 8; k++) begin
      clr(); s.ret = 1'b1; s.ret_reg = 16'hBEEF;
      e.pc = 16'(16'h002C - k); e.full = 1'b0; e.empty = (k == 8);
      step();
    end
    clr(); s.ret = 1'b1; s.ret_reg = 16'h1234; e.pc = 16'h1234; step();

    // Halt: pc holds, flags/RAS untouched, stall and controls ignored
    clr(); s.ret = 1'b1; s.ret_reg = 16'h0040; e.pc = 16'h0040; step();
    clr(); s.halt_in = 1'b1; s.call = 1'b1; s.set_z = 1'b1; s.alu_z = 1'b1;
    e.hlt = 1'b1; step();
    clr(); s.call = 1'b1; s.call_off = 12'h010; s.set_nv = 1'b1; s.alu_n = 1'b1; step();
    clr(); s.stall = 1'b1; s.branch = 1'b1; s.cond = 3'b111; s.br_off = 9'h005; step();
    clr(); s.ret = 1'b1; s.ret_reg = 16'h0077; step();

    // Mid-cycle asynchronous reset
    @(posedge clk);
    #3;
    chk("queue drained", 32'(q.size()), 32'd0);
    rst_n = 1'b0;
    #1;
    e = '{pc: 16'h0000, hlt: 1'b0, z: 1'b0, n: 1'b0, v: 1'b0,
          empty: 1'b1, full: 1'b0, ovf: 1'b0};
    check_state(e, "midreset");

    clr(); e.pc = 16'h0001; step();
    clr(); e.pc = 16'h0002; step();
    @(posedge clk);
    #3;
    chk("final queue drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
